spi_reg_bridge: RTL and testbench
=================================

# spi_reg_bridge

Command-decoding stage directly downstream of the SPI slave. It consumes received bytes (`rx_byte`/`rx_dv`) and feeds transmit bytes back (`tx_byte`/`tx_wr`). It turns SPI frames into single-cycle read and write accesses on a simple register bus toward the RTC core's timekeeping registers. One frame is delimited by chip-select: a command byte, then a burst of data bytes.

## Interface
Parameters:
- `ADDRW`, default 3: register address width; 2^ADDRW registers.
- `DW`, default 8: data width; must equal the SPI slave byte width.

Ports (reset `rst` is synchronous, active-high; clock is `clk`):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `ss`  in  1  raw SPI chip-select, active-low, asynchronous to `clk`
- `rx_byte`  in  DW  received byte from the SPI slave
- `rx_dv`  in  1  one-cycle strobe; `rx_byte` is valid
- `status`  in  DW  status byte shifted out during the command byte
- `tx_byte`  out  DW  next byte to serialize
- `tx_wr`  out  1  one-cycle load strobe to the SPI slave
- `reg_addr`  out  ADDRW  register bus address
- `reg_wdata`  out  DW  register write data
- `reg_we`  out  1  one-cycle write strobe
- `reg_re`  out  1  one-cycle read strobe
- `reg_rdata`  in  DW  read data, valid the cycle after `reg_re`
- `busy`  out  1  high while a frame is open

## Operation
- `ss` passes through a 2-flop synchronizer. `ss_fall` and `ss_rise` are edges of the synchronized value.
- Command byte format:
  - bit DW-1: 1 = read, 0 = write.
  - bits ADDRW-1:0: start address.
  - All other bits are ignored.

States:
- **IDLE**
  - On `ss_fall`: `tx_byte` <= `status`, pulse `tx_wr`, `busy` <= 1, go to CMD.
  - `rx_dv` in IDLE is ignored.
- **CMD**
  - On `rx_dv`: latch `addr` <= `rx_byte[ADDRW-1:0]`.
  - If the read bit is set: drive `reg_addr`, pulse `reg_re`, go to RD_FETCH.
  - Otherwise go to WRITE.
- **RD_FETCH** (one cycle)
  - `tx_byte` <= `reg_rdata`, pulse `tx_wr`, go to READ.
- **READ**
  - On each `rx_dv` (master dummy byte): `addr` <= next address, pulse `reg_re` at the new address, go to RD_FETCH.
- **WRITE**
  - On each `rx_dv`: `reg_addr` <= `addr`, `reg_wdata` <= `rx_byte`, pulse `reg_we`, then `addr` <= next address.
- Next address is `addr+1` modulo 2^ADDRW, so it wraps from 2^ADDRW-1 to 0.

Any state:
- `ss_rise` forces IDLE and clears `busy`. It has priority over a same-cycle `rx_dv`, which is dropped.
- `ss_fall` while not IDLE (a glitch) restarts at CMD with a status load.

Reset:
- All outputs go to 0 and the state goes to IDLE.
- The synchronizer resets to 1 (deselected).
- Reset mid-frame abandons the frame. No strobe is issued in the reset cycle or the cycle after.

## Timing
- Strobes (`tx_wr`, `reg_we`, `reg_re`) are exactly one cycle wide. They never overlap each other.
- Write: `reg_we` is asserted the cycle after `rx_dv`.
- Read:
  - `reg_re` is asserted the cycle after `rx_dv`.
  - `tx_wr` with the fetched data follows one cycle later, 2 cycles after `rx_dv`.
  - This must land before the next byte's first SCLK falling edge, which requires `clk` ≥ 8× SCLK.
- Status load: `tx_wr` is asserted 3 cycles after the raw `ss` falls (2 for the synchronizer, 1 registered).
- `busy` rises with the status `tx_wr` and falls the cycle after `ss_rise` is detected.

## Configuration
- `SPI_REG_BRIDGE_AUTOINC_EN`
  - Defined: burst auto-increment as described above.
  - Undefined: the next address always equals `addr`. A burst repeatedly reads or writes the same register.
  - Strobe timing is identical in both builds.

## Structure
- Package `spi_reg_pkg`:
  - state enum (IDLE, CMD, RD_FETCH, READ, WRITE)
  - `CMD_RD_BIT` = DW-1
  - default `ADDRW`/`DW` constants
- Sub-module `sync2`: 2-flop synchronizer with reset value parameter, used for `ss`.
- Address increment is a local function.

## Test plan
- Reset release with `ss`=1: all outputs 0, `busy`=0. Then drop `ss` with `status`=0xA5 → `tx_wr` pulse with `tx_byte`=0xA5 exactly 3 cycles later.
- Write burst: cmd 0x02, data 0x11, 0x22 → `reg_we` at addr 2 with 0x11, then addr 3 with 0x22, each 1 cycle after `rx_dv`.
- Read burst: cmd 0x87, with `reg_rdata` modelled as addr×0x10.
  - AUTOINC build: `reg_re` addr 7 → `tx_byte`=0x70. After a dummy byte: addr 0 (wrap) → 0x00.
  - Non-AUTOINC build: addr 7 repeats.
- `ss_rise` in the same cycle as `rx_dv` during WRITE → no `reg_we`, state IDLE, `busy`=0.
- `rx_dv` with `ss` deasserted (IDLE) → no strobes.
- Reset asserted mid-read burst → outputs 0 next cycle. A new frame afterwards behaves as a fresh frame.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and constants for spi_reg_bridge
package spi_reg_pkg;

   localparam int DEF_ADDRW  = 3;
   localparam int DEF_DW     = 8;
   localparam int CMD_RD_BIT = DEF_DW - 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_RD_FETCH,
      ST_READ,
      ST_WRITE
   } state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with configurable reset value
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic ff1;
   logic ff2;

   always_ff @(posedge clk) begin
      if (rst) begin
         ff1 <= RST_VAL;
         ff2 <= RST_VAL;
      end else begin
         ff1 <= d;
         ff2 <= ff1;
      end
   end

   assign q = ff2;

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI frame to register bus bridge; burst auto-increment via SPI_REG_BRIDGE_AUTOINC_EN
module spi_reg_bridge
   import spi_reg_pkg::*;
#(
   parameter int ADDRW = DEF_ADDRW,
   parameter int DW    = DEF_DW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ss,
   input  logic [DW-1:0]    rx_byte,
   input  logic             rx_dv,
   input  logic [DW-1:0]    status,
   output logic [DW-1:0]    tx_byte,
   output logic             tx_wr,
   output logic [ADDRW-1:0] reg_addr,
   output logic [DW-1:0]    reg_wdata,
   output logic             reg_we,
   output logic             reg_re,
   input  logic [DW-1:0]    reg_rdata,
   output logic             busy
);

   state_t           state, state_nxt;
   logic [ADDRW-1:0] addr, addr_nxt;
   logic [DW-1:0]    tx_byte_nxt, reg_wdata_nxt;
   logic [ADDRW-1:0] reg_addr_nxt;
   logic             tx_wr_nxt, reg_we_nxt, reg_re_nxt, busy_nxt;
   logic             ss_s, ss_d, ss_fall, ss_rise;

   function automatic logic [ADDRW-1:0] next_addr(input logic [ADDRW-1:0] a);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
      return a + ADDRW'(1);
`else
      return a;
`endif
   endfunction

   sync2 #(.RST_VAL(1'b1)) u_ss_sync (
      .clk (clk),
      .rst (rst),
      .d   (ss),
      .q   (ss_s)
   );

   always_ff @(posedge clk) begin
      if (rst) ss_d <= 1'b1;
      else     ss_d <= ss_s;
   end

   assign ss_fall = ss_d & ~ss_s;
   assign ss_rise = ~ss_d & ss_s;

   always_comb begin
      state_nxt     = state;
      addr_nxt      = addr;
      tx_byte_nxt   = tx_byte;
      tx_wr_nxt     = 1'b0;
      reg_addr_nxt  = reg_addr;
      reg_wdata_nxt = reg_wdata;
      reg_we_nxt    = 1'b0;
      reg_re_nxt    = 1'b0;
      busy_nxt      = busy;

      // Deselect wins over everything, a reselect (or glitch) always restarts the frame.
      if (ss_rise) begin
         state_nxt = ST_IDLE;
         busy_nxt  = 1'b0;
      end else if (ss_fall) begin
         tx_byte_nxt = status;
         tx_wr_nxt   = 1'b1;
         busy_nxt    = 1'b1;
         state_nxt   = ST_CMD;
      end else begin
         case (state)
            ST_CMD: if (rx_dv) begin
               addr_nxt = rx_byte[ADDRW-1:0];
               if (rx_byte[CMD_RD_BIT]) begin
                  reg_addr_nxt = rx_byte[ADDRW-1:0];
                  reg_re_nxt   = 1'b1;
                  state_nxt    = ST_RD_FETCH;
               end else begin
                  state_nxt = ST_WRITE;
               end
            end
            ST_RD_FETCH: begin
               tx_byte_nxt = reg_rdata;
               tx_wr_nxt   = 1'b1;
               state_nxt   = ST_READ;
            end
            ST_READ: if (rx_dv) begin
               addr_nxt     = next_addr(addr);
               reg_addr_nxt = next_addr(addr);
               reg_re_nxt   = 1'b1;
               state_nxt    = ST_RD_FETCH;
            end
            ST_WRITE: if (rx_dv) begin
               reg_addr_nxt  = addr;
               reg_wdata_nxt = rx_byte;
               reg_we_nxt    = 1'b1;
               addr_nxt      = next_addr(addr);
            end
            ST_IDLE: ;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr      <= '0;
         tx_byte   <= '0;
         tx_wr     <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         addr      <= addr_nxt;
         tx_byte   <= tx_byte_nxt;
         tx_wr     <= tx_wr_nxt;
         reg_addr  <= reg_addr_nxt;
         reg_wdata <= reg_wdata_nxt;
         reg_we    <= reg_we_nxt;
         reg_re    <= reg_re_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;

   localparam logic [1:0] K_TX = 2'd0, K_WE = 2'd1, K_RE = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [2:0]  addr;
      logic [7:0]  data;
      logic [31:0] cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ss = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_dv = 1'b0;
   logic [7:0] status = 8'h00;
   logic [7:0] tx_byte;
   logic       tx_wr;
   logic [2:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       busy;

   logic [31:0] cyc = 0;
   ev_t         obs_q[$];
   ev_t         exp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          overlap_cnt = 0;
   int          stretch_cnt = 0;
   logic        p_tx = 1'b0, p_we = 1'b0, p_re = 1'b0;
   logic [2:0]  m_addr;
   logic        m_rd;

   spi_reg_bridge #(.ADDRW(3), .DW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .ss        (ss),
      .rx_byte   (rx_byte),
      .rx_dv     (rx_dv),
      .status    (status),
      .tx_byte   (tx_byte),
      .tx_wr     (tx_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   // Register file stand-in: register n reads back as n*0x10.
   assign reg_rdata = {1'b0, reg_addr, 4'h0};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_wr)  obs_q.push_back({K_TX, 3'd0, tx_byte, cyc});
      if (reg_we) obs_q.push_back({K_WE, reg_addr, reg_wdata, cyc});
      if (reg_re) obs_q.push_back({K_RE, reg_addr, 8'h00, cyc});
      if (int'(tx_wr) + int'(reg_we) + int'(reg_re) > 1) overlap_cnt++;
      if ((tx_wr & p_tx) | (reg_we & p_we) | (reg_re & p_re)) stretch_cnt++;
      p_tx = tx_wr;
      p_we = reg_we;
      p_re = reg_re;
   end

   function automatic logic [2:0] model_next(input logic [2:0] a);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
      return a + 3'd1;
`else
      return a;
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q;
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic drive_rx(input logic [7:0] b, output logic [31:0] rc);
      rx_byte = b;
      rx_dv   = 1'b1;
      rc      = cyc;
      tick();
      rx_dv   = 1'b0;
      rx_byte = 8'($urandom);
      repeat (7) tick();
   endtask

   task automatic open_frame(input logic [7:0] st);
      status = st;
      ss     = 1'b0;
      exp_q.push_back({K_TX, 3'd0, st, cyc + 32'd3});
      repeat (5) tick();
   endtask

   task automatic close_frame;
      ss = 1'b1;
      repeat (4) tick();
   endtask

   task automatic send_cmd(input logic [7:0] cmd);
      logic [31:0] rc;
      drive_rx(cmd, rc);
      m_addr = cmd[2:0];
      m_rd   = cmd[7];
      if (m_rd) begin
         exp_q.push_back({K_RE, m_addr, 8'h00, rc + 32'd1});
         exp_q.push_back({K_TX, 3'd0, {1'b0, m_addr, 4'h0}, rc + 32'd2});
      end
   endtask

   task automatic send_data(input logic [7:0] b);
      logic [31:0] rc;
      drive_rx(b, rc);
      if (m_rd) begin
         m_addr = model_next(m_addr);
         exp_q.push_back({K_RE, m_addr, 8'h00, rc + 32'd1});
         exp_q.push_back({K_TX, 3'd0, {1'b0, m_addr, 4'h0}, rc + 32'd2});
      end else begin
         exp_q.push_back({K_WE, m_addr, b, rc + 32'd1});
         m_addr = model_next(m_addr);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      ss  = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      n_chk++;
      if ({tx_byte, tx_wr, reg_addr, reg_wdata, reg_we, reg_re} !== 29'd0)
         $display("FAIL reset_outputs: got %h want 0", {tx_byte, tx_wr, reg_addr, reg_wdata, reg_we, reg_re});
      else n_pass++;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
      else n_pass++;
      status = 8'hA5;
      ss     = 1'b0;
      tick();
      tick();
      n_chk++;
      if (tx_wr !== 1'b0) $display("FAIL status_early: tx_wr got %b want 0", tx_wr);
      else n_pass++;
      tick();
      n_chk++;
      if ({tx_wr, tx_byte} !== {1'b1, 8'hA5}) $display("FAIL status_load: got %h want 1a5", {tx_wr, tx_byte});
      else n_pass++;
      n_chk++;
      if (busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", busy);
      else n_pass++;
      tick();
      n_chk++;
      if (tx_wr !== 1'b0) $display("FAIL status_width: tx_wr got %b want 0", tx_wr);
      else n_pass++;
      close_frame();
      n_chk++;
      if (busy !== 1'b0) $display("FAIL busy_fall: got %b want 0", busy);
      else n_pass++;
      clear_q();
   endtask

   task automatic test_write_burst;
      clear_q();
      open_frame(8'h3C);
      send_cmd(8'h02);
      send_data(8'h11);
      send_data(8'h22);
      close_frame();
      n_chk++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL wr_count: got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL wr_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_read_burst;
      clear_q();
      open_frame(8'h5A);
      send_cmd(8'h87);
      send_data(8'hFF);
      send_data(8'hFF);
      close_frame();
      n_chk++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL rd_count: got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL rd_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random_frames;
      for (int f = 0; f < 6; f++) begin
         clear_q();
         open_frame(8'($urandom));
         send_cmd(8'($urandom));
         for (int j = 0; j < int'($urandom_range(4, 1)); j++) send_data(8'($urandom));
         close_frame();
         n_chk++;
         if (obs_q.size() !== exp_q.size())
            $display("FAIL rnd%0d_count: got %0d want %0d", f, obs_q.size(), exp_q.size());
         else n_pass++;
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL rnd%0d_ev%0d: got %h want %h", f, i, obs_q[i], exp_q[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_rise_drops_rx;
      clear_q();
      open_frame(8'h0F);
      send_cmd(8'h01);
      send_data(8'h33);
      ss = 1'b1;
      tick();
      tick();
      rx_byte = 8'h44;
      rx_dv   = 1'b1;
      tick();
      rx_dv   = 1'b0;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL rise_busy: got %b want 0", busy);
      else n_pass++;
      repeat (3) tick();
      n_chk++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL rise_count: got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL rise_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_idle_rx;
      logic [31:0] rc;
      clear_q();
      for (int i = 0; i < 4; i++) drive_rx(8'($urandom) | 8'h80, rc);
      n_chk++;
      if (obs_q.size() !== 0) $display("FAIL idle_rx: got %0d strobes want 0", obs_q.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid_read;
      logic [31:0] r;
      clear_q();
      open_frame(8'hC3);
      send_cmd(8'h85);
      rx_byte = 8'hFF;
      rx_dv   = 1'b1;
      m_addr  = model_next(m_addr);
      exp_q.push_back({K_RE, m_addr, 8'h00, cyc + 32'd1});
      tick();
      rx_dv = 1'b0;
      rst   = 1'b1;
      tick();
      n_chk++;
      if ({tx_byte, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, busy} !== 30'd0)
         $display("FAIL midrst_outputs: got %h want 0", {tx_byte, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, busy});
      else n_pass++;
      rst = 1'b0;
      r   = cyc;
      tick();
      n_chk++;
      if ({tx_wr, reg_we, reg_re, busy} !== 4'd0)
         $display("FAIL midrst_after: got %b want 0000", {tx_wr, reg_we, reg_re, busy});
      else n_pass++;
      exp_q.push_back({K_TX, 3'd0, 8'hC3, r + 32'd3});
      repeat (4) tick();
      send_cmd(8'h06);
      send_data(8'h9A);
      send_data(8'hB7);
      close_frame();
      n_chk++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL midrst_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_strobe_rules;
      n_chk++;
      if (overlap_cnt !== 0) $display("FAIL strobe_overlap: got %0d want 0", overlap_cnt);
      else n_pass++;
      n_chk++;
      if (stretch_cnt !== 0) $display("FAIL strobe_width: got %0d want 0", stretch_cnt);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_read_burst();
      test_random_frames();
      test_rise_drops_rx();
      test_idle_rx();
      test_reset_mid_read();
      test_strobe_rules();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
